// File: rtl/riscv_id.sv
// RV32I decode stage: register file with write-through, OP/OP-IMM/LUI decode,
// and a registered operand bundle for riscv_ex with stall hold and bubble insertion.
module riscv_id #(
  parameter int XLEN = 32,
  parameter int REGN = 32,
  parameter int REGA = $clog2(REGN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instr,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic            stall,
  input  logic            wb_en,
  input  logic [REGA-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [REGA-1:0] rd,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [5:0]      shamt,
  output logic [2:0]      funct3,
  output logic            invertb,
  output logic            ex_valid,
  output logic            illegal
);

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0]      opcode;
  logic [REGA-1:0] rd_f;
  logic [REGA-1:0] rs1;
  logic [REGA-1:0] rs2;
  logic [2:0]      f3;
  logic [6:0]      f7;

  assign opcode = instr[6:0];
  assign rd_f   = REGA'(instr[11:7]);
  assign f3     = instr[14:12];
  assign rs1    = REGA'(instr[19:15]);
  assign rs2    = REGA'(instr[24:20]);
  assign f7     = instr[31:25];

  logic [XLEN-1:0] regs_q [REGN];
  logic [XLEN-1:0] regs_d [REGN];

  always_comb begin
    regs_d = regs_q;
    if (wb_en && wb_rd != '0) regs_d[wb_rd] = wb_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

  // Reads forward a same-cycle writeback so back-to-back dependents see new data.
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != '0) rs1_val = (wb_en && wb_rd == rs1) ? wb_data : regs_q[rs1];
    if (rs2 != '0) rs2_val = (wb_en && wb_rd == rs2) ? wb_data : regs_q[rs2];
  end

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;

  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_u = XLEN'({instr[31:12], 12'b0});

  logic            legal;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic [5:0]      dec_shamt;
  logic [2:0]      dec_f3;
  logic            dec_inv;

  always_comb begin
    legal     = 1'b0;
    dec_a     = '0;
    dec_b     = '0;
    dec_shamt = '0;
    dec_f3    = '0;
    dec_inv   = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_a     = rs1_val;
        dec_b     = rs2_val;
        dec_shamt = {1'b0, rs2_val[4:0]};
        dec_f3    = f3;
        if (f7 == F7_BASE) begin
          legal = 1'b1;
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          legal   = 1'b1;
          dec_b   = '0 - rs2_val;
          dec_inv = 1'b1;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          legal   = 1'b1;
          dec_inv = 1'b1;
        end
      end
      OPC_IMM: begin
        dec_a     = rs1_val;
        dec_b     = imm_i;
        dec_shamt = {1'b0, instr[24:20]};
        dec_f3    = f3;
        case (f3)
          3'b001: legal = (f7 == F7_BASE);
          3'b101: begin
            legal   = (f7 == F7_BASE) || (f7 == F7_ALT);
            dec_inv = instr[30];
          end
          default: legal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        legal = 1'b1;
        dec_b = imm_u;
      end
      default: legal = 1'b0;
    endcase
  end

  logic consume;
  assign consume     = instr_valid && !stall;
  assign instr_ready = !stall && rst_n;

  logic [REGA-1:0] rd_q, rd_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [5:0]      shamt_q, shamt_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            invertb_q, invertb_d;
  logic            ex_valid_q, ex_valid_d;
  logic            illegal_q, illegal_d;

  // Stall holds the bundle; otherwise load the decoded instruction or a bubble.
  always_comb begin
    rd_d       = rd_q;
    a_d        = a_q;
    b_d        = b_q;
    shamt_d    = shamt_q;
    funct3_d   = funct3_q;
    invertb_d  = invertb_q;
    ex_valid_d = ex_valid_q;
    illegal_d  = 1'b0;
    if (!stall) begin
      rd_d       = '0;
      a_d        = '0;
      b_d        = '0;
      shamt_d    = '0;
      funct3_d   = '0;
      invertb_d  = 1'b0;
      ex_valid_d = 1'b0;
      illegal_d  = consume && !legal;
      if (consume && legal) begin
        rd_d       = rd_f;
        a_d        = dec_a;
        b_d        = dec_b;
        shamt_d    = dec_shamt;
        funct3_d   = dec_f3;
        invertb_d  = dec_inv;
        ex_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      shamt_q    <= '0;
      funct3_q   <= '0;
      invertb_q  <= 1'b0;
      ex_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      rd_q       <= rd_d;
      a_q        <= a_d;
      b_q        <= b_d;
      shamt_q    <= shamt_d;
      funct3_q   <= funct3_d;
      invertb_q  <= invertb_d;
      ex_valid_q <= ex_valid_d;
      illegal_q  <= illegal_d;
    end
  end

  assign rd       = rd_q;
  assign a        = a_q;
  assign b        = b_q;
  assign shamt    = shamt_q;
  assign funct3   = funct3_q;
  assign invertb  = invertb_q;
  assign ex_valid = ex_valid_q;
  assign illegal  = illegal_q;

endmodule
